// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save multi-operand accumulator.
// Operands stream in over a valid/ready handshake and fold into a
// redundant (sum, carry) pair with one 3:2 compression per operand.
// After the last operand the pair resolves to binary CHUNK bits per
// cycle, and the result is offered on an output handshake.
// Ports:
//   clk, rst             clock, async active-high reset
//   in_valid/in_ready    operand handshake
//   in_data, in_last     operand, final-operand marker
//   out_valid/out_ready  result handshake
//   out_data             sum of operands mod 2^ACC_W
//   out_count            operand count, saturating
module csa_stream_accumulator #(
   parameter int WIDTH = 4,
   parameter int ACC_W = 8,
   parameter int CHUNK = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count
);

   localparam int NCH = ACC_W / CHUNK;
   localparam int K_W = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_RESOLVE,
      ST_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [ACC_W-1:0] r_s;
   logic [ACC_W-1:0] r_c;
   logic [ACC_W-1:0] r_res;
   logic [CNT_W-1:0] r_cnt;
   logic [K_W-1:0]   r_k;
   logic             r_cr;
   logic [ACC_W-1:0] w_x;
   logic [ACC_W-1:0] w_maj;
   logic [CHUNK:0]   w_csum;
   logic             w_fire;
   logic             w_last_chunk;

   assign w_x    = ACC_W'(in_data);
   assign w_maj  = (r_s & r_c) | (r_s & w_x) | (r_c & w_x);
   assign w_fire = in_valid && in_ready;

   // One chunk of the ripple resolve, carry chained through r_cr.
   assign w_csum = {1'b0, r_s[int'(r_k)*CHUNK +: CHUNK]}
                 + {1'b0, r_c[int'(r_k)*CHUNK +: CHUNK]}
                 + (CHUNK+1)'(r_cr);

   assign w_last_chunk = (r_k == K_W'(NCH - 1));

   // rst term keeps in_ready low for the whole reset pulse.
   assign in_ready  = (r_state == ST_ACC) && !rst;
   assign out_valid = (r_state == ST_DONE);
   assign out_data  = r_res;
   assign out_count = r_cnt;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_ACC: begin
            if (w_fire && in_last)
               w_next = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            if (w_last_chunk)
               w_next = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready)
               w_next = ST_ACC;
         end
         default: w_next = ST_ACC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_ACC;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s   <= '0;
         r_c   <= '0;
         r_res <= '0;
         r_cnt <= '0;
         r_k   <= '0;
         r_cr  <= 1'b0;
      end else begin
         unique case (r_state)
            ST_ACC: begin
               if (w_fire) begin
                  r_s <= r_s ^ r_c ^ w_x;
                  // Carry out of the MSB is dropped: mod 2^ACC_W.
                  r_c <= {w_maj[ACC_W-2:0], 1'b0};
                  if (r_cnt != '1)
                     r_cnt <= r_cnt + CNT_W'(1);
                  if (in_last) begin
                     r_k  <= '0;
                     r_cr <= 1'b0;
                  end
               end
            end
            ST_RESOLVE: begin
               r_res[int'(r_k)*CHUNK +: CHUNK] <= w_csum[CHUNK-1:0];
               r_cr <= w_csum[CHUNK];
               r_k  <= r_k + K_W'(1);
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_s   <= '0;
                  r_c   <= '0;
                  r_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// tb_csa_stream_accumulator: randomized bench for the accumulator,
// checked against a plain integer-sum reference model.
module tb_csa_stream_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [7:0] out_count;

   int n_tot = 0;
   int n_bad = 0;
   int q[$];

   csa_stream_accumulator #(
      .WIDTH(4), .ACC_W(8), .CHUNK(4), .CNT_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams q, then checks latency, result and handshake.
   task automatic run_set(input int gap_max, input int hold);
      int sum;
      int exp_d;
      int exp_c;
      int w;
      sum = 0;
      foreach (q[i]) sum += q[i];
      exp_d = sum % 256;
      exp_c = (q.size() > 255) ? 255 : q.size();
      out_ready = 1'b0;
      foreach (q[i]) begin
         repeat ($urandom_range(gap_max, 0)) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            in_data  = 4'($urandom);
            tick();
         end
         in_valid = 1'b1;
         in_data  = 4'(q[i]);
         in_last  = (i == q.size() - 1);
         chk("in_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (hold == 0) out_ready = 1'b1;
      chk("busy_rdy", in_ready, 0);
      chk("lat0", out_valid, 0);
      tick();
      chk("lat1", out_valid, 0);
      tick();
      chk("lat2", out_valid, 1);
      w = 0;
      while (!out_valid && w < 20) begin
         tick();
         w++;
      end
      chk("data", out_data, exp_d);
      chk("count", out_count, exp_c);
      chk("done_rdy", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = 4'($urandom);
         in_last  = 1'($urandom);
         tick();
         chk("hold_v", out_valid, 1);
         chk("hold_d", out_data, exp_d);
         chk("hold_c", out_count, exp_c);
         chk("hold_rdy", in_ready, 0);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("hs_v", out_valid, 0);
      chk("hs_rdy", in_ready, 1);
      out_ready = 1'b0;
      q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("rst_rdy", in_ready, 0);
      chk("rst_v", out_valid, 0);
      chk("rst_d", out_data, 0);
      chk("rst_c", out_count, 0);
      rst = 1'b0;
      tick();

      q = '{3, 5, 7};
      run_set(0, 0);

      for (int i = 0; i < 32; i++) q.push_back(15);
      run_set(0, 1);

      q = '{9};
      run_set(0, 0);
      q = '{1, 2};
      run_set(0, 0);

      q = '{6, 11, 4};
      run_set(1, 5);

      for (int i = 0; i < 260; i++) q.push_back(1);
      run_set(0, 0);

      for (int s = 0; s < 100; s++) begin
         int n;
         n = $urandom_range(8, 1);
         for (int i = 0; i < n; i++) q.push_back($urandom_range(15, 0));
         run_set(3, $urandom_range(2, 0));
      end

      in_valid = 1'b1;
      in_data  = 4'd15;
      in_last  = 1'b0;
      tick();
      in_last  = 1'b1;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("mid_v", out_valid, 0);
      chk("mid_rdy", in_ready, 0);
      chk("mid_c", out_count, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("post_rdy", in_ready, 1);
      q = '{4};
      run_set(0, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
